// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: valid/ready command sequencer for an a74194 shift register (or cascade).
// Define SHIFT_SEQ_RING_EN to add cmd_ring, which rotates instead of shifting in cmd_sin.
module shift_seq_ctrl #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [COUNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0]   cmd_data,
    input  logic               cmd_sin,
`ifdef SHIFT_SEQ_RING_EN
    input  logic               cmd_ring,
`endif
    input  logic [WIDTH-1:0]   Q_in,
    output logic               M1,
    output logic               M0,
    output logic               SR,
    output logic               SL,
    output logic [WIDTH-1:0]   D,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'b00, OP_SHR = 2'b01, OP_SHL = 2'b10, OP_HOLD = 2'b11;
    logic [1:0]         state_q, state_d, m_q, m_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d, n;
    logic               sr_q, sr_d, sl_q, sl_d, done_q, done_d, accept, go;
    logic [WIDTH-1:0]   d_q, d_d, result_q, result_d;
    assign cmd_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign accept    = cmd_valid && cmd_ready;
    assign n         = (cmd_op == OP_LOAD) ? COUNT_W'(1) : cmd_cnt;
    assign go        = accept && n != '0;
    // A zero count skips RUN entirely so the register is never touched.
    always_comb begin
        state_d  = accept ? (go ? RUN : DONE) :
                   (state_q == RUN && cnt_q <= COUNT_W'(1)) ? DONE :
                   (state_q == DONE) ? IDLE : state_q;
        cnt_d    = accept ? n : (state_q == RUN && cnt_q != '0) ? cnt_q - COUNT_W'(1) : cnt_q;
        m_d      = go ? ((cmd_op == OP_LOAD || cmd_op == OP_HOLD) ? ~cmd_op : cmd_op) :
                   (state_d == RUN) ? m_q : 2'b00;
        sr_d     = go ? (cmd_op == OP_SHR && cmd_sin) : (state_d == RUN && sr_q);
        sl_d     = go ? (cmd_op == OP_SHL && cmd_sin) : (state_d == RUN && sl_q);
        d_d      = (go && cmd_op == OP_LOAD) ? cmd_data : d_q;
        done_d   = state_q == DONE;
        result_d = (state_q == DONE) ? Q_in : result_q;
    end
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            m_q      <= 2'b00;
            sr_q     <= 1'b0;
            sl_q     <= 1'b0;
            d_q      <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            sr_q     <= sr_d;
            sl_q     <= sl_d;
            d_q      <= d_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end
`ifdef SHIFT_SEQ_RING_EN
    logic ring_q, ring_d;
    assign ring_d = accept ? cmd_ring : ring_q;
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) ring_q <= 1'b0;
        else      ring_q <= ring_d;
    end
    // Mode pins are only 01/10 while shifting, so they double as the ring-direction gate.
    assign SR = (ring_q && m_q == 2'b01) ? Q_in[WIDTH-1] : sr_q;
    assign SL = (ring_q && m_q == 2'b10) ? Q_in[0] : sl_q;
`else
    assign SR = sr_q;
    assign SL = sl_q;
`endif
    assign M1     = m_q[1];
    assign M0     = m_q[0];
    assign D      = d_q;
    assign done   = done_q;
    assign result = result_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed commands against a transaction-level model plus an a74194 register model.
module tb_shift_seq_ctrl;
    localparam int W = 4, CW = 4;
`ifdef SHIFT_SEQ_RING_EN
    localparam bit RING = 1'b1;
`else
    localparam bit RING = 1'b0;
`endif
    logic clk = 1'b0, clr = 1'b1, cmd_valid = 1'b0, cmd_sin = 1'b0, cmd_ring = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [CW-1:0] cmd_cnt = '0;
    logic [W-1:0] cmd_data = '0, q = '0;
    logic cmd_ready, M1, M0, SR, SL, busy, done;
    logic [W-1:0] D, result;
    int vectors = 0, miscompares = 0, cyc = 0, k = 0, n = 0;
    bit act = 1'b0, m_ring = 1'b0, m_sin = 1'b0, chk_en = 1'b0;
    logic [1:0] m_op = 2'b00;
    logic [W-1:0] m_data = '0, m_res = '0, prev_result = '0, prev_d = '0;

    shift_seq_ctrl #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_sin(cmd_sin),
`ifdef SHIFT_SEQ_RING_EN
        .cmd_ring(cmd_ring),
`endif
        .Q_in(q), .M1(M1), .M0(M0), .SR(SR), .SL(SL), .D(D),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act_v, exp_v);
        end
    endtask

    function automatic logic [W-1:0] predict(input logic [1:0] op, input int cnt, input bit sin,
                                             input bit ring, input logic [W-1:0] qv, input logic [W-1:0] data);
        int mask = (1 << W) - 1;
        int v = int'(qv);
        int c = cnt % W;
        int r;
        case (op)
            2'b00: r = int'(data);
            2'b01: r = ring ? ((v << c) | (v >> (W - c))) : ((v << cnt) | (sin ? (1 << cnt) - 1 : 0));
            2'b10: r = ring ? ((v >> c) | (v << (W - c))) :
                       (cnt >= W ? (sin ? mask : 0) : ((v >> cnt) | (sin ? (((1 << cnt) - 1) << (W - cnt)) : 0)));
            default: r = v;
        endcase
        return r[W-1:0];
    endfunction

    function automatic logic [1:0] mode_of(input logic [1:0] op);
        return (op == 2'b00) ? 2'b11 : (op == 2'b11) ? 2'b00 : op;
    endfunction

    always @(posedge clk) begin
        case ({M1, M0})
            2'b11: q <= D;
            2'b01: q <= {q[W-2:0], SR};
            2'b10: q <= {SL, q[W-1:1]};
            default: ;
        endcase
    end

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            act = 1'b0;
            prev_result = '0;
            prev_d = '0;
        end else begin
            cyc++;
            if (cmd_valid && (!act || cyc - 1 - k >= n + 1)) begin
                if (act) begin
                    prev_result = m_res;
                    if (m_op == 2'b00) prev_d = m_data;
                end
                act = 1'b1;
                k = cyc;
                m_op = cmd_op;
                n = (cmd_op == 2'b00) ? 1 : int'(cmd_cnt);
                m_sin = cmd_sin;
                m_ring = RING && cmd_ring;
                m_data = cmd_data;
                m_res = predict(cmd_op, n, cmd_sin, m_ring, q, cmd_data);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int t;
            bit run, e_ready, e_busy, e_done, e_sr, e_sl;
            logic [1:0] e_m;
            logic [W-1:0] e_res, e_d;
            t = cyc - k;
            run = act && t < n;
            e_ready = !act || t >= n + 1;
            e_busy = !e_ready;
            e_done = act && t == n + 1;
            e_m = run ? mode_of(m_op) : 2'b00;
            e_sr = run && m_op == 2'b01 && (m_ring ? q[W-1] : m_sin);
            e_sl = run && m_op == 2'b10 && (m_ring ? q[0] : m_sin);
            e_res = (act && t >= n + 1) ? m_res : prev_result;
            e_d = (act && m_op == 2'b00) ? m_data : prev_d;
            check("cmd_ready", cmd_ready, e_ready);
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("mode", {M1, M0}, e_m);
            check("SR", SR, e_sr);
            check("SL", SL, e_sl);
            check("result", result, e_res);
            check("D", D, e_d);
        end
    end

    task automatic send(input logic [1:0] op, input int cnt, input logic [W-1:0] data,
                        input logic sin, input logic ring);
        int i;
        for (i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) check("ready_timeout", 0, 1);
        cmd_op = op;
        cmd_cnt = CW'(cnt);
        cmd_data = data;
        cmd_sin = sin;
        cmd_ring = ring;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 40 && !done; i++) @(negedge clk);
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mode"}, {M1, M0}, 2'b00);
        check({tag, "_SR_SL"}, {SR, SL}, 2'b00);
        check({tag, "_D"}, D, 4'b0000);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_result"}, result, 4'b0000);
        check({tag, "_ready"}, cmd_ready, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #3 clr = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        clr = 1'b1;
        chk_en = 1'b1;
        send(2'b00, 0, 4'b1100, 1'b0, 1'b0);
        wait_done();
        check("load_result", result, 4'b1100);
        send(2'b01, 3, 4'b0000, 1'b1, 1'b0);
        wait_done();
        check("shr3_result", result, 4'b0111);
        send(2'b10, 2, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        cmd_op = 2'b01;
        cmd_cnt = 4'd7;
        cmd_sin = 1'b1;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done();
        check("shl2_result", result, 4'b0001);
        check("shl2_q", q, 4'b0001);
        send(2'b01, 0, 4'b0000, 1'b1, 1'b0);
        wait_done();
        check("shr0_result", result, 4'b0001);
        send(2'b11, 2, 4'b0000, 1'b1, 1'b0);
        wait_done();
        check("hold2_result", result, 4'b0001);
        send(2'b01, 5, 4'b0000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 clr = 1'b0;
        #1 check_reset_outputs("abort");
        check("abort_q", q, 4'b0100);
        @(negedge clk);
        clr = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_no_done", done, 1'b0);
        send(2'b00, 0, 4'b1010, 1'b0, 1'b0);
        wait_done();
        check("load2_result", result, 4'b1010);
        send(2'b10, 15, 4'b0000, 1'b1, 1'b0);
        wait_done();
        check("shl15_result", result, 4'b1111);
`ifdef SHIFT_SEQ_RING_EN
        send(2'b00, 0, 4'b1000, 1'b0, 1'b0);
        wait_done();
        send(2'b01, 4, 4'b0000, 1'b0, 1'b1);
        wait_done();
        check("ring_shr4_result", result, 4'b1000);
        send(2'b10, 1, 4'b0000, 1'b1, 1'b1);
        wait_done();
        check("ring_shl1_result", result, 4'b0100);
`endif
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
